fifo_stream_reader: RTL and testbench

//   Read-side master for the synchronous FIFO. Pops words with rd_en, absorbs the FIFO's
//   1-cycle read latency, and presents the data as a valid/ready stream to a downstream

---
 rtl/fifo_stream_reader.sv | 113 +++++++++++
 tb/tb_fifo_stream_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side master for a synchronous FIFO with one cycle of read latency.
// Words popped from the FIFO land in a two-entry skid buffer whose head
// drives a valid/ready stream. A read is only issued when the buffer can
// take the word on arrival, so backpressure never loses data.

module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    logic [FIFO_WIDTH-1:0] buf_head;
    logic [FIFO_WIDTH-1:0] buf_tail;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic [2:0]            room_limit;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_head;

    // Handshake decode and read issue: a read goes out only when the buffered
    // plus in-flight words leave a free slot, counting the slot a pop frees now.
    always_comb begin
        pop        = m_valid && m_ready;
        push       = inflight && !fifo_underflow;
        occupancy  = {1'b0, buf_cnt} + {2'b00, inflight};
        room_limit = 3'd2 + {2'b00, pop};
        fifo_rd_en = enable && !fifo_empty && !rst && (occupancy < room_limit);
    end

    // Remember whether a read was issued last cycle, so its data is captured now.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Two-entry output buffer. The head is the stream word; a simultaneous
    // push and pop keeps occupancy and shifts the tail forward in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_head <= '0;
            buf_tail <= '0;
            buf_cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_head <= fifo_data_out;
                    end else begin
                        buf_tail <= fifo_data_out;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_head <= fifo_data_out;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= fifo_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count words delivered on the stream; wraps naturally at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

    // Sticky flag for a read that the FIFO reported as an underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_err <= 1'b0;
        end else if (inflight && fifo_underflow) begin
            underflow_err <= 1'b1;
        end
    end

    // The issue rule must never let a word arrive into a full, stalled buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (buf_cnt == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Drives fifo_stream_reader from a behavioural one-cycle-latency FIFO model.
// Every word written into the model is queued as expected stream output; a
// monitor compares the stream head against that queue every valid cycle.

module tb_fifo_stream_reader;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic [CW-1:0] rd_count;
    logic          underflow_err;

    logic [W-1:0]  fifo_q[$];
    bit            uf_q[$];
    logic [W-1:0]  exp_q[$];

    int checks    = 0;
    int errors    = 0;
    int rd_pulses = 0;
    int delivered = 0;

    fifo_stream_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Write one word into the FIFO model; words flagged as underflow are not expected on the stream.
    task automatic applyStimulus(input logic [W-1:0] word, input bit uf);
        fifo_q.push_back(word);
        uf_q.push_back(uf);
        fifo_empty = 1'b0;
        if (!uf) exp_q.push_back(word);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO model: a read sampled at this edge presents its data during the next cycle.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses++;
            if (fifo_q.size() > 0) begin
                fifo_data_out  <= fifo_q.pop_front();
                fifo_underflow <= uf_q.pop_front();
                fifo_empty     <= (fifo_q.size() == 0);
            end else begin
                fifo_underflow <= 1'b1;
            end
        end else begin
            fifo_underflow <= 1'b0;
        end
    end

    // Monitor: every valid stream word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            delivered = 0;
        end else if (m_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("stream_extra_word", {16'h0, m_data}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("stream_data", {16'h0, m_data}, {16'h0, exp_q[0]});
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    task automatic doReset();
        rst    = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        fifo_q.delete();
        uf_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        rst = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < limit) begin
            tick();
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [5:0] exp_rd;
        logic [5:0] exp_mv;
        int         cnt_rd;
        int         cnt_mv;
        int         sent;
        int         cyc;

        rst            = 1'b1;
        enable         = 1'b1;
        m_ready        = 1'b1;
        fifo_empty     = 1'b0;
        fifo_data_out  = '0;
        fifo_underflow = 1'b0;
        fifo_q.push_back(16'h0055);
        uf_q.push_back(1'b0);

        // Reset held two cycles with a non-empty FIFO and enable high
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_rd_count", rd_count, 0);
        checkOutput("reset_underflow_err", underflow_err, 0);
        checkOutput("reset_fifo_rd_en", fifo_rd_en, 0);
        doReset();

        // Three words at full rate
        $display("[TB] basic three-word stream");
        applyStimulus(16'h00A1, 0);
        applyStimulus(16'h00B2, 0);
        applyStimulus(16'h00C3, 0);
        enable  = 1'b1;
        m_ready = 1'b1;
        exp_rd = 6'b000111;
        exp_mv = 6'b011100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("basic_rd_en_c%0d", c), fifo_rd_en, exp_rd[c]);
            checkOutput($sformatf("basic_m_valid_c%0d", c), m_valid, exp_mv[c]);
            tick();
        end
        checkOutput("basic_rd_count", rd_count, 3);
        doReset();

        // Backpressure: only two reads may be outstanding while stalled
        $display("[TB] backpressure");
        rd_pulses = 0;
        for (int i = 0; i < 5; i++) applyStimulus(16'h1000 + 16'(i), 0);
        enable  = 1'b1;
        m_ready = 1'b0;
        repeat (8) tick();
        checkOutput("bp_rd_pulses", rd_pulses, 2);
        checkOutput("bp_m_valid", m_valid, 1);
        checkOutput("bp_m_data", m_data, 16'h1000);
        m_ready = 1'b1;
        waitDrain("bp_drain", 50);
        checkOutput("bp_rd_count", rd_count, 5);
        doReset();

        // Empty FIFO: no reads, no output
        $display("[TB] empty fifo");
        enable = 1'b1;
        m_ready = 1'b1;
        cnt_rd = 0;
        cnt_mv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt_rd++;
            if (m_valid) cnt_mv++;
            tick();
        end
        checkOutput("empty_rd_en_cycles", cnt_rd, 0);
        checkOutput("empty_m_valid_cycles", cnt_mv, 0);
        doReset();

        // Underflow reported on a read: word dropped, sticky error
        $display("[TB] underflow");
        enable = 1'b1;
        m_ready = 1'b1;
        applyStimulus(16'h0077, 1);
        cnt_mv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid) cnt_mv++;
            tick();
        end
        checkOutput("uf_m_valid_cycles", cnt_mv, 0);
        checkOutput("uf_err_set", underflow_err, 1);
        checkOutput("uf_rd_count", rd_count, 0);
        applyStimulus(16'h0088, 0);
        waitDrain("uf_followup_drain", 20);
        checkOutput("uf_err_sticky", underflow_err, 1);
        checkOutput("uf_followup_count", rd_count, 1);
        doReset();
        @(negedge clk);
        checkOutput("uf_err_cleared", underflow_err, 0);
        tick();

        // Counter wrap: 17 words on a 4-bit counter
        $display("[TB] counter wrap");
        for (int i = 0; i < 17; i++) applyStimulus(16'h2000 + 16'(i), 0);
        enable  = 1'b1;
        m_ready = 1'b1;
        waitDrain("wrap_drain", 100);
        checkOutput("wrap_rd_count", rd_count, 1);
        doReset();

        // Random ready/enable over 10000 words
        $display("[TB] random backpressure");
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            m_ready = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 7) != 0);
            if (fifo_q.size() < 4 && $urandom_range(0, 3) != 0) begin
                applyStimulus(16'($urandom), 0);
                sent++;
            end
            tick();
            cyc++;
        end
        checkOutput("random_words_sent", sent, 10000);
        enable  = 1'b1;
        m_ready = 1'b1;
        waitDrain("random_drain", 200);
        checkOutput("random_delivered", delivered, 10000);
        checkOutput("random_rd_count", rd_count, 32'(delivered % 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
